// File: rtl/tpu_pkg.sv
// Shared types and constants for the TPU sequencer.
// The optional perf counters are enabled with `define TPU_CTRL_PERF_EN.
package tpu_pkg;

  localparam int unsigned TPU_DIM    = 8;
  localparam int unsigned TPU_IDX_W  = 5;
  localparam int unsigned TPU_PERF_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DRAIN   = 2'd2
  } tpu_ctrl_state_t;

  // Number of systolic shift steps for a DIM x DIM multiply.
  function automatic int unsigned tpu_steps(input int unsigned dim);
    return 3 * dim - 2;
  endfunction

endpackage

// File: rtl/tpu_perf_cnt.sv
// Saturating event counter, cleared only by reset.
module tpu_perf_cnt
  import tpu_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  inc_i,
  output logic [TPU_PERF_W-1:0] cnt_o
);

  logic [TPU_PERF_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + TPU_PERF_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/tpu_ctrl.sv
// Matrix-unit sequencer: element loads, compute shift sequence, pipeline stall.
// Optional busy/stall perf counters under `define TPU_CTRL_PERF_EN.
module tpu_ctrl
  import tpu_pkg::*;
#(
  parameter int unsigned DIM    = TPU_DIM,
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  start_i,
  input  logic                  wren_A_i,
  input  logic                  wren_B_i,
  input  logic                  wren_C_i,
  input  logic [TPU_IDX_W-1:0]  row_i,
  input  logic [TPU_IDX_W-1:0]  col_i,
  input  logic [DATA_W-1:0]     data_i,
  output logic                  tpu_wr_A_o,
  output logic                  tpu_wr_B_o,
  output logic                  tpu_wr_C_o,
  output logic [TPU_IDX_W-1:0]  tpu_row_o,
  output logic [TPU_IDX_W-1:0]  tpu_col_o,
  output logic [DATA_W-1:0]     tpu_data_o,
  output logic                  tpu_shift_o,
  output logic                  stall_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [TPU_PERF_W-1:0] perf_busy_cnt_o,
  output logic [TPU_PERF_W-1:0] perf_stall_cnt_o
);

  localparam int unsigned STEPS = tpu_steps(DIM);
  localparam int unsigned CNT_W = $clog2(3 * DIM);
  localparam int unsigned CMP_W = TPU_IDX_W + 1;

  tpu_ctrl_state_t        state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [2:0]             wr_q, wr_d;
  logic [TPU_IDX_W-1:0]   row_q, row_d;
  logic [TPU_IDX_W-1:0]   col_q, col_d;
  logic [DATA_W-1:0]      data_q, data_d;
  logic                   shift_q, shift_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  logic [2:0]             wren_c;
  logic                   cmd_c;
  logic                   multi_wr_c;
  logic                   in_range_c;

  assign wren_c     = {wren_A_i, wren_B_i, wren_C_i};
  assign cmd_c      = start_i | (|wren_c);
  assign multi_wr_c = (wren_A_i & wren_B_i) | (wren_A_i & wren_C_i) | (wren_B_i & wren_C_i);
  assign in_range_c = ({1'b0, row_i} < CMP_W'(DIM)) && ({1'b0, col_i} < CMP_W'(DIM));

  // Commands arriving while not IDLE are held in EX until the first IDLE cycle.
  assign stall_o = cmd_c & (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = '0;
    row_d   = row_q;
    col_d   = col_q;
    data_d  = data_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = COMPUTE;
          cnt_d   = '0;
          err_d   = |wren_c;
        end else if (|wren_c) begin
          if (multi_wr_c || !in_range_c) begin
            err_d = 1'b1;
          end else begin
            wr_d   = wren_c;
            row_d  = row_i;
            col_d  = col_i;
            data_d = data_i;
          end
        end
      end
      COMPUTE: begin
        if (cnt_q == CNT_W'(STEPS - 1)) begin
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DRAIN: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    // Status outputs are registered views of the next state.
    shift_d = (state_d == COMPUTE);
    done_d  = (state_d == DRAIN);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= '0;
      row_q   <= '0;
      col_q   <= '0;
      data_q  <= '0;
      shift_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      row_q   <= row_d;
      col_q   <= col_d;
      data_q  <= data_d;
      shift_q <= shift_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign tpu_wr_A_o  = wr_q[2];
  assign tpu_wr_B_o  = wr_q[1];
  assign tpu_wr_C_o  = wr_q[0];
  assign tpu_row_o   = row_q;
  assign tpu_col_o   = col_q;
  assign tpu_data_o  = data_q;
  assign tpu_shift_o = shift_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

`ifdef TPU_CTRL_PERF_EN
  tpu_perf_cnt u_perf_busy (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .inc_i   (busy_q),
    .cnt_o   (perf_busy_cnt_o)
  );

  tpu_perf_cnt u_perf_stall (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .inc_i   (stall_o),
    .cnt_o   (perf_stall_cnt_o)
  );
`else
  assign perf_busy_cnt_o  = '0;
  assign perf_stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_tpu_ctrl.sv
// Scoreboard bench for tpu_ctrl: the driver queues expected writes, errors and
// done pulses; a negedge monitor pops and compares whenever the DUT presents one.
module tb_tpu_ctrl;
  import tpu_pkg::*;

  localparam int unsigned DIM   = 8;
  localparam int unsigned DW    = 32;
  localparam int          STEPS = int'(tpu_steps(DIM));
  localparam int          D3    = 3 * int'(DIM);
`ifdef TPU_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  logic          start_i, wren_A_i, wren_B_i, wren_C_i;
  logic [4:0]    row_i, col_i;
  logic [DW-1:0] data_i;
  logic          tpu_wr_A_o, tpu_wr_B_o, tpu_wr_C_o;
  logic [4:0]    tpu_row_o, tpu_col_o;
  logic [DW-1:0] tpu_data_o;
  logic          tpu_shift_o, stall_o, busy_o, done_o, err_o;
  logic [31:0]   perf_busy_cnt_o, perf_stall_cnt_o;

  tpu_ctrl #(.DIM(DIM), .DATA_W(DW)) dut (
    .clk_i            (clk_i),
    .rst_n_i          (rst_n_i),
    .start_i          (start_i),
    .wren_A_i         (wren_A_i),
    .wren_B_i         (wren_B_i),
    .wren_C_i         (wren_C_i),
    .row_i            (row_i),
    .col_i            (col_i),
    .data_i           (data_i),
    .tpu_wr_A_o       (tpu_wr_A_o),
    .tpu_wr_B_o       (tpu_wr_B_o),
    .tpu_wr_C_o       (tpu_wr_C_o),
    .tpu_row_o        (tpu_row_o),
    .tpu_col_o        (tpu_col_o),
    .tpu_data_o       (tpu_data_o),
    .tpu_shift_o      (tpu_shift_o),
    .stall_o          (stall_o),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .err_o            (err_o),
    .perf_busy_cnt_o  (perf_busy_cnt_o),
    .perf_stall_cnt_o (perf_stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc++;

  typedef struct {
    int          cyc;
    logic [2:0]  wr;
    logic [4:0]  row;
    logic [4:0]  col;
    logic [31:0] data;
  } wr_exp_t;

  wr_exp_t wr_q[$];
  int      done_q[$];
  int      err_q[$];
  int      n_pass  = 0;
  int      n_total = 0;
  int      run     = 0;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Monitor: pop one expectation for every strobe/pulse the DUT presents.
  always @(negedge clk_i) begin
    if (!rst_n_i) begin
      run = 0;
    end else begin
      if (tpu_wr_A_o | tpu_wr_B_o | tpu_wr_C_o) begin
        if (wr_q.size() == 0) begin
          chk("wr_unexpected", 96'({tpu_wr_A_o, tpu_wr_B_o, tpu_wr_C_o}), 96'(0));
        end else begin
          wr_exp_t e;
          e = wr_q.pop_front();
          chk("wr_event",
              96'({32'(cyc), tpu_wr_A_o, tpu_wr_B_o, tpu_wr_C_o, tpu_row_o, tpu_col_o, tpu_data_o}),
              96'({32'(e.cyc), e.wr, e.row, e.col, e.data}));
        end
      end
      if (err_o) begin
        if (err_q.size() == 0) chk("err_unexpected", 96'(cyc), 96'(0));
        else chk("err_cycle", 96'(cyc), 96'(err_q.pop_front()));
      end
      if (done_o) begin
        if (done_q.size() == 0) chk("done_unexpected", 96'(cyc), 96'(0));
        else chk("done_cycle", 96'(cyc), 96'(done_q.pop_front()));
        chk("shift_count", 96'(run), 96'(STEPS));
        chk("done_busy_shift", 96'({busy_o, tpu_shift_o}), 96'(2'b10));
        run = 0;
      end else if (tpu_shift_o) begin
        run++;
      end else begin
        run = 0;
      end
    end
  end

  task automatic at_neg(input int t);
    forever begin
      @(negedge clk_i);
      if (cyc >= t) break;
    end
  endtask

  task automatic goto_pos(input int t);
    forever begin
      @(posedge clk_i);
      #1;
      if (cyc >= t) break;
    end
  endtask

  task automatic clr();
    start_i  = 1'b0;
    wren_A_i = 1'b0;
    wren_B_i = 1'b0;
    wren_C_i = 1'b0;
  endtask

  // One-cycle command; caller sits just after a posedge. s_edge = sampling edge.
  task automatic cmd(input logic s, input logic [2:0] w, input logic [4:0] r,
                     input logic [4:0] c, input logic [31:0] d,
                     input bit exp_wr, input bit exp_err, output int s_edge);
    wr_exp_t e;
    start_i = s;
    {wren_A_i, wren_B_i, wren_C_i} = w;
    row_i  = r;
    col_i  = c;
    data_i = d;
    s_edge = cyc + 1;
    if (exp_wr) begin
      e.cyc = s_edge; e.wr = w; e.row = r; e.col = c; e.data = d;
      wr_q.push_back(e);
    end
    if (exp_err) err_q.push_back(s_edge);
    if (s) done_q.push_back(s_edge + D3 - 2);
    @(posedge clk_i);
    #1;
    clr();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, got cycle %0d, expected below 10000", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    rst_n_i = 1'b0;
    clr();
    row_i = '0; col_i = '0; data_i = '0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("reset_outs",
        96'({tpu_wr_A_o, tpu_wr_B_o, tpu_wr_C_o, tpu_row_o, tpu_col_o, tpu_data_o,
             tpu_shift_o, stall_o, busy_o, done_o, err_o}), 96'(0));
    chk("reset_perf", 96'({perf_busy_cnt_o, perf_stall_cnt_o}), 96'(0));
    @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
    goto_pos(cyc + 2);

    // Legal writes, including back-to-back and array-edge indices.
    cmd(1'b0, 3'b100, 5'd3, 5'd5, 32'hDEAD_BEEF, 1'b1, 1'b0, s);
    at_neg(s + 1);
    chk("wr_hold", 96'({tpu_wr_A_o, tpu_wr_B_o, tpu_wr_C_o, tpu_row_o, tpu_col_o, tpu_data_o}),
        96'({3'b000, 5'd3, 5'd5, 32'hDEAD_BEEF}));
    goto_pos(s + 2);
    cmd(1'b0, 3'b010, 5'd7, 5'd7, 32'h0000_0001, 1'b1, 1'b0, s);
    cmd(1'b0, 3'b001, 5'd0, 5'd0, 32'hA5A5_5A5A, 1'b1, 1'b0, s);

    // Illegal commands: dropped, one err pulse each.
    cmd(1'b0, 3'b001, 5'd8, 5'd0, 32'h1111_1111, 1'b0, 1'b1, s);
    cmd(1'b0, 3'b100, 5'd0, 5'd8, 32'h2222_2222, 1'b0, 1'b1, s);
    cmd(1'b0, 3'b110, 5'd1, 5'd1, 32'h3333_3333, 1'b0, 1'b1, s);
    cmd(1'b0, 3'b010, 5'd31, 5'd31, 32'h4444_4444, 1'b0, 1'b1, s);
    cmd(1'b0, 3'b100, 5'd1, 5'd2, 32'h5555_6666, 1'b1, 1'b0, s);
    goto_pos(cyc + 2);

    // Single compute.
    cmd(1'b1, 3'b000, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0, s);
    at_neg(s);
    chk("cmp_start", 96'({busy_o, tpu_shift_o, stall_o}), 96'(3'b110));
    at_neg(s + D3 - 2);
    chk("cmp_drain_busy", 96'(busy_o), 96'(1));
    at_neg(s + D3 - 1);
    chk("cmp_idle", 96'({busy_o, tpu_shift_o, done_o}), 96'(0));
    at_neg(s + D3);
    chk("perf_busy", 96'(perf_busy_cnt_o), 96'(PERF ? D3 - 1 : 0));
    chk("perf_stall0", 96'(perf_stall_cnt_o), 96'(0));
    goto_pos(s + D3 + 1);

    // Write held in EX during a compute: stalled, then issued once.
    cmd(1'b1, 3'b000, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0, s);
    goto_pos(s + 4);
    wren_B_i = 1'b1; row_i = 5'd2; col_i = 5'd6; data_i = 32'h1234_5678;
    begin
      wr_exp_t e;
      e.cyc = s + D3; e.wr = 3'b010; e.row = 5'd2; e.col = 5'd6; e.data = 32'h1234_5678;
      wr_q.push_back(e);
    end
    at_neg(s + 4);
    chk("stall_first", 96'(stall_o), 96'(1));
    at_neg(s + D3 - 2);
    chk("stall_drain", 96'(stall_o), 96'(1));
    at_neg(s + D3 - 1);
    chk("stall_release", 96'({stall_o, busy_o}), 96'(0));
    goto_pos(s + D3);
    clr();
    at_neg(s + D3 + 1);
    chk("perf_stall", 96'(perf_stall_cnt_o), 96'(PERF ? D3 - 5 : 0));
    goto_pos(s + D3 + 2);

    // start together with a write: compute runs, write dropped, err pulses.
    cmd(1'b1, 3'b100, 5'd1, 5'd1, 32'h7777_7777, 1'b0, 1'b1, s);
    goto_pos(s + D3 + 1);

    // start held through the whole compute: next one accepted right after DRAIN.
    start_i = 1'b1;
    s = cyc + 1;
    done_q.push_back(s + D3 - 2);
    done_q.push_back(s + 2 * D3 - 2);
    at_neg(s + D3 - 1);
    chk("b2b_gap", 96'({busy_o, stall_o}), 96'(2'b00));
    goto_pos(s + D3);
    clr();
    at_neg(s + D3);
    chk("b2b_restart", 96'({busy_o, tpu_shift_o}), 96'(2'b11));
    goto_pos(s + 2 * D3);
    chk("b2b_idle", 96'(busy_o), 96'(0));

    // Reset at compute step 10: immediate clear, no done afterwards.
    cmd(1'b1, 3'b000, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0, s);
    void'(done_q.pop_back());
    goto_pos(s + 10);
    rst_n_i = 1'b0;
    #1;
    chk("async_reset",
        96'({tpu_wr_A_o, tpu_wr_B_o, tpu_wr_C_o, tpu_row_o, tpu_col_o, tpu_data_o,
             tpu_shift_o, stall_o, busy_o, done_o, err_o}), 96'(0));
    chk("async_reset_perf", 96'({perf_busy_cnt_o, perf_stall_cnt_o}), 96'(0));
    goto_pos(cyc + 2);
    rst_n_i = 1'b1;
    goto_pos(cyc + D3 + 2);
    chk("post_reset_idle", 96'({busy_o, tpu_shift_o}), 96'(0));
    cmd(1'b0, 3'b100, 5'd4, 5'd4, 32'hCAFE_F00D, 1'b1, 1'b0, s);
    goto_pos(cyc + 3);

    chk("wr_q_drained", 96'(wr_q.size()), 96'(0));
    chk("err_q_drained", 96'(err_q.size()), 96'(0));
    chk("done_q_drained", 96'(done_q.size()), 96'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
